// File: rtl/ahb_mem_arbiter.sv
// AHB-Lite master for the RV32I core: round-robin arbitration between the I-cache and
// D-cache, issuing SINGLE/INCR bursts with pipelined address and data phases.
module ahb_mem_arbiter #(
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_done,
  output logic             i_err,
  input  logic             d_req,
  input  logic [31:0]      d_addr,
  input  logic [LEN_W-1:0] d_len,
  input  logic             d_write,
  input  logic [31:0]      d_wdata,
  output logic             d_wnext,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  output logic             d_err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t           state;
  logic             owner_d;
  logic             last_grant_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic             dp_valid;
  logic             dp_write;

  logic             i_cand, d_cand, grant_d, accept, dp_done;
  logic [31:0]      sel_addr;
  logic [LEN_W-1:0] sel_len, eff_len;

  assign HSIZE     = 3'b010;
  assign HMASTLOCK = 1'b0;

  always_comb begin
    // Any done pulse blocks arbitration, giving one idle cycle between transactions.
    i_cand   = i_req && !i_done && !d_done;
    d_cand   = d_req && !i_done && !d_done;
    grant_d  = d_cand && (!i_cand || !last_grant_d);
    sel_addr = grant_d ? d_addr : i_addr;
    sel_len  = grant_d ? d_len : i_len;
    if (sel_len == '0)
      eff_len = LEN_W'(1);
    else if (sel_len > LEN_W'(MAX_BEATS))
      eff_len = LEN_W'(MAX_BEATS);
    else
      eff_len = sel_len;
    accept  = (state == XFER) && (HTRANS != HT_IDLE) && HREADY && !HRESP;
    dp_done = dp_valid && HREADY;
    d_wnext = accept && owner_d && HWRITE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
      len_q        <= '0;
      issued       <= '0;
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      HADDR        <= '0;
      HTRANS       <= HT_IDLE;
      HWRITE       <= 1'b0;
      HBURST       <= 3'b000;
      HPROT        <= 4'b0011;
      HWDATA       <= '0;
      i_rvalid     <= 1'b0;
      i_rdata      <= '0;
      i_done       <= 1'b0;
      i_err        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cand || d_cand) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            len_q        <= eff_len;
            issued       <= LEN_W'(1);
            dp_valid     <= 1'b0;
            HADDR        <= sel_addr;
            HTRANS       <= HT_NONSEQ;
            HWRITE       <= grant_d && d_write;
            HBURST       <= (eff_len == LEN_W'(1)) ? 3'b000 : 3'b001;
            HPROT        <= grant_d ? 4'b0011 : 4'b0010;
            state        <= XFER;
          end
        end
        XFER, DRAIN: begin
          if (dp_valid && HRESP) begin
            HTRANS <= HT_IDLE;
            if (HREADY) begin
              // Second error cycle: the errored beat is dropped and the rest abandoned.
              dp_valid <= 1'b0;
              state    <= IDLE;
              if (owner_d) begin
                d_err  <= 1'b1;
                d_done <= 1'b1;
              end else begin
                i_err  <= 1'b1;
                i_done <= 1'b1;
              end
            end else begin
              state <= DRAIN;
            end
          end else begin
            if (dp_done && !dp_write) begin
              if (owner_d) begin
                d_rdata  <= HRDATA;
                d_rvalid <= 1'b1;
              end else begin
                i_rdata  <= HRDATA;
                i_rvalid <= 1'b1;
              end
            end
            if (accept) begin
              dp_valid <= 1'b1;
              dp_write <= HWRITE;
              if (HWRITE)
                HWDATA <= d_wdata;
              if (issued < len_q) begin
                HADDR  <= HADDR + 32'd4;
                HTRANS <= HT_SEQ;
                issued <= issued + LEN_W'(1);
              end else begin
                HTRANS <= HT_IDLE;
                state  <= DRAIN;
              end
            end else if (dp_done) begin
              dp_valid <= 1'b0;
            end
            if ((state == DRAIN) && dp_done) begin
              state <= IDLE;
              if (owner_d)
                d_done <= 1'b1;
              else
                i_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
